// File: rtl/jtbubl_snd_romcache.sv
// Direct-mapped 16-line read cache between the sound Z80 ROM port and its SDRAM slot.
// Byte requests from the CPU become 16-bit word fetches; repeated reads hit locally.
`timescale 1ns/1ps

module jtbubl_snd_romcache (
  input  logic        clk,
  input  logic        snd_rstn,
  input  logic        flush,
  input  logic [14:0] rom_addr,
  input  logic        rom_cs,
  output logic [7:0]  rom_data,
  output logic        rom_ok,
  output logic [13:0] mem_addr,
  output logic        mem_cs,
  input  logic [15:0] mem_data,
  input  logic        mem_ok
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;

  logic [15:0] line_valid;
  logic [9:0]  tag_mem  [16];
  logic [15:0] data_mem [16];

  logic [14:0] out_addr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [14:0] cap_addr;
  logic        discard;   // a flush hit the pending fill, so its data must not land

  logic [3:0]  rd_idx, fill_idx;
  logic        req, hit;
  logic        hit_load, start_miss, fill_done, fill_write;

  assign rd_idx   = rom_addr[4:1];
  assign fill_idx = cap_addr[4:1];
  assign rom_ok   = rom_cs & out_valid & (out_addr == rom_addr);
  assign rom_data = out_data;
  assign req      = rom_cs & ~rom_ok;
  assign hit      = line_valid[rd_idx] & (tag_mem[rd_idx] == rom_addr[14:5]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    hit_load   = 1'b0;
    start_miss = 1'b0;
    fill_done  = 1'b0;
    fill_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            hit_load = ~flush;
          end else begin
            start_miss = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      // mem_ok is ignored here: it may still belong to the previous address
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ok) begin
          fill_done  = 1'b1;
          fill_write = ~(discard | flush);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge snd_rstn) begin
    if (!snd_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk or negedge snd_rstn) begin
    if (!snd_rstn) begin
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      cap_addr <= '0;
      discard  <= 1'b0;
    end else if (start_miss) begin
      mem_cs   <= 1'b1;
      mem_addr <= rom_addr[14:1];
      cap_addr <= rom_addr;
      discard  <= 1'b0;
    end else begin
      if (fill_done) mem_cs <= 1'b0;
      if (flush && state_q != IDLE) discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge snd_rstn) begin
    if (!snd_rstn)       line_valid <= '0;
    else if (flush)      line_valid <= '0;
    else if (fill_write) line_valid[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk or negedge snd_rstn) begin
    if (!snd_rstn) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= 8'hFF;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (hit_load) begin
      out_valid <= 1'b1;
      out_addr  <= rom_addr;
      out_data  <= rom_addr[0] ? data_mem[rd_idx][15:8] : data_mem[rd_idx][7:0];
    end else if (fill_write) begin
      out_valid <= 1'b1;
      out_addr  <= cap_addr;
      out_data  <= cap_addr[0] ? mem_data[15:8] : mem_data[7:0];
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      tag_mem[fill_idx]  <= cap_addr[14:5];
      data_mem[fill_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_jtbubl_snd_romcache.sv
// Scoreboard bench for jtbubl_snd_romcache: a behavioural cache/memory model predicts
// data, hit/miss and latency; a negedge monitor compares each rom_ok event.
`timescale 1ns/1ps

module tb_jtbubl_snd_romcache;

  logic        clk = 1'b0;
  logic        snd_rstn = 1'b0;
  logic        flush = 1'b0;
  logic [14:0] rom_addr = '0;
  logic        rom_cs = 1'b0;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [13:0] mem_addr;
  logic        mem_cs;
  logic [15:0] mem_data = '0;
  logic        mem_ok = 1'b0;

  jtbubl_snd_romcache dut (
    .clk      (clk),
    .snd_rstn (snd_rstn),
    .flush    (flush),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .mem_addr (mem_addr),
    .mem_cs   (mem_cs),
    .mem_data (mem_data),
    .mem_ok   (mem_ok)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SDRAM model ----------------
  logic [15:0] mem [16384];
  bit          stale_mode = 0;
  int          lat_cfg = 1;
  int          wait_cnt = 0;
  logic [13:0] prev_maddr = '0;
  logic        prev_cs = 1'b0;
  int          fetch_count = 0;
  int          fetch_cycle = 0;
  logic [13:0] fetch_addr = '0;
  int          cycle = 0;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (mem_cs && !prev_cs) begin
      fetch_count++;
      fetch_cycle = cycle;
      fetch_addr  = mem_addr;
      wait_cnt    = 0;
      lat_cfg     = int'($urandom_range(1, 4));
    end else if (mem_cs) begin
      check("mem_addr_stable", 32'(mem_addr), 32'(fetch_addr));
      wait_cnt++;
    end
    prev_cs = mem_cs;
    if (stale_mode) begin
      // ok held high; data lags the address by one cycle
      mem_ok   = 1'b1;
      mem_data = mem[prev_maddr];
    end else begin
      mem_ok   = mem_cs && (wait_cnt >= lat_cfg);
      mem_data = mem_ok ? mem[mem_addr] : 16'($urandom);
    end
    prev_maddr = mem_addr;
  end

  // ---------------- reference cache model ----------------
  bit          m_valid [16];
  logic [13:0] m_word  [16];
  bit          m_out_valid = 0;
  logic [14:0] m_out_addr = '0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_out_valid = 0;
  endtask

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    bit          fetch;
    int          issue_cyc;
    int          fc;
    int          exp_lat;   // -1: any miss latency of at least 3
  } exp_t;

  exp_t sb[$];

  // ---------------- monitor ----------------
  logic        prev_ok = 1'b0;
  logic [14:0] prev_raddr = '0;
  exp_t        mon_e;
  int          mon_lat;

  always @(negedge clk) begin
    if (snd_rstn && rom_ok && (!prev_ok || rom_addr != prev_raddr)) begin
      if (sb.size() == 0) begin
        check("unexpected_rom_ok", 32'(rom_addr), 32'h7FFFF);
      end else begin
        mon_e   = sb.pop_front();
        mon_lat = cycle - mon_e.issue_cyc;
        check("rom_data", 32'(rom_data), 32'(mon_e.data));
        check("fetch_count", 32'(fetch_count - mon_e.fc), mon_e.fetch ? 32'd1 : 32'd0);
        if (!mon_e.fetch) begin
          check("hit_latency", 32'(mon_lat), 32'(mon_e.exp_lat));
        end else begin
          check("miss_mem_addr", 32'(fetch_addr), 32'(mon_e.addr[14:1]));
          check("mem_cs_start", 32'(fetch_cycle - mon_e.issue_cyc), 32'd1);
          if (mon_e.exp_lat > 0) check("miss_latency", 32'(mon_lat), 32'(mon_e.exp_lat));
          else                   check("miss_latency_min", 32'(mon_lat >= 3), 32'd1);
        end
      end
    end
    prev_ok    = rom_ok;
    prev_raddr = rom_addr;
  end

  // ---------------- stimulus ----------------
  task automatic read(input logic [14:0] a, input int miss_lat);
    exp_t        e;
    logic [15:0] w;
    bit          done;
    if (rom_cs && rom_addr == a) begin
      @(posedge clk); #1;
      rom_cs = 1'b0;
    end
    @(posedge clk); #1;
    w           = mem[a[14:1]];
    e.addr      = a;
    e.data      = a[0] ? w[15:8] : w[7:0];
    e.issue_cyc = cycle;
    e.fc        = fetch_count;
    if (m_out_valid && m_out_addr == a) begin
      e.fetch = 0; e.exp_lat = 0;
    end else if (m_valid[a[4:1]] && m_word[a[4:1]] == a[14:1]) begin
      e.fetch = 0; e.exp_lat = 1;
    end else begin
      e.fetch = 1; e.exp_lat = miss_lat;
    end
    sb.push_back(e);
    rom_addr = a;
    rom_cs   = 1'b1;
    m_valid[a[4:1]] = 1;
    m_word[a[4:1]]  = a[14:1];
    m_out_valid     = 1;
    m_out_addr      = a;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (rom_ok) done = 1;
    end
    if (!done) check("rom_ok_timeout", 32'(a), 32'h7FFFF);
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    rom_cs = 1'b0;
    flush  = 1'b1;
    @(posedge clk); #1;
    flush  = 1'b0;
    model_clear();
  endtask

  // mode 0: drop rom_cs in WAIT; mode 1: flush in WAIT; mode 2: reset in WAIT
  task automatic disturb(input logic [14:0] a, input int mode);
    bit seen;
    @(posedge clk); #1;
    rom_cs = 1'b0;
    @(posedge clk); #1;
    rom_addr = a;
    rom_cs   = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (mem_cs) seen = 1;
    end
    check("disturb_issue_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    check("disturb_in_wait", 32'(mem_cs), 32'd1);
    case (mode)
      0: begin
        rom_cs = 1'b0;
        m_valid[a[4:1]] = 1;
        m_word[a[4:1]]  = a[14:1];
        m_out_valid     = 1;
        m_out_addr      = a;
      end
      1: begin
        rom_cs = 1'b0;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush  = 1'b0;
        model_clear();
      end
      default: begin
        snd_rstn = 1'b0;
        #1;
        check("rst_async_mem_cs", 32'(mem_cs), 32'd0);
        check("rst_mid_rom_ok", 32'(rom_ok), 32'd0);
        check("rst_mid_rom_data", 32'(rom_data), 32'hFF);
        rom_cs = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        snd_rstn = 1'b1;
        model_clear();
      end
    endcase
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (!mem_cs) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("disturb_fill_end", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [14:0] ra;
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    mem[14'h091] = 16'hBEEF;
    model_clear();

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_ok", 32'(rom_ok), 32'd0);
    check("rst_rom_data", 32'(rom_data), 32'hFF);
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    snd_rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_mem_cs", 32'(mem_cs), 32'd0);
    check("post_rst_rom_data", 32'(rom_data), 32'hFF);
    read(15'h0000, -1);

    // cold miss then hit on the other byte
    read(15'h0123, -1);
    read(15'h0122, -1);

    // conflict eviction on index 1
    read(15'h0002, -1);
    read(15'h0022, -1);
    read(15'h0002, -1);

    // stale mem_ok held high: only WAIT may accept
    @(posedge clk); #1;
    stale_mode = 1;
    read(15'h4567, 3);
    read(15'h7ABC, 3);
    read(15'h0123, 3);
    @(posedge clk); #1;
    stale_mode = 0;
    @(posedge clk);

    // abandoned fill still writes the line
    disturb(15'h1235, 0);
    read(15'h1234, -1);
    read(15'h1235, -1);

    // flush during WAIT discards the fill
    disturb(15'h2468, 1);
    read(15'h2468, -1);

    // randomized traffic over a few conflicting tags
    for (int n = 0; n < 250; n++) begin
      ra = {10'($urandom_range(0, 3) * 97), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 19) == 0) do_flush();
      read(ra, -1);
    end

    // reset mid-fill invalidates everything
    disturb(15'h7FFF, 2);
    read(15'h0122, -1);
    read(15'h0002, -1);
    read(15'h7FFF, -1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtbubl_snd_romcache.md
# jtbubl_snd_romcache

Small direct-mapped read cache between the sound Z80 ROM port and the SDRAM read slot assigned to sound. It converts the CPU's byte requests into 16-bit word fetches and serves repeated fetches in tight sound-driver loops without an SDRAM round trip. It sits directly upstream of the sound CPU subsystem, driving its `rom_data`/`rom_ok` and consuming its `rom_addr`/`rom_cs`.

## Interface
- No parameters; geometry is fixed at 16 lines × 16-bit word.
- `clk` in 1: system clock.
- `snd_rstn` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous invalidate-all, e.g. during ROM download.
- `rom_addr` in 15: CPU byte address.
- `rom_cs` in 1: CPU ROM access request; address is stable while high.
- `rom_data` out 8: byte returned to the CPU.
- `rom_ok` out 1: `rom_data` is valid for the current `rom_addr`.
- `mem_addr` out 14: SDRAM word address.
- `mem_cs` out 1: SDRAM read request.
- `mem_data` in 16: SDRAM read data.
- `mem_ok` in 1: `mem_data` is valid for `mem_addr`.

## Operation
- **Address split:**
  - byte select = `rom_addr[0]`
  - index = `rom_addr[4:1]`
  - tag = `rom_addr[14:5]` (10 bits)
  - Per line: valid bit, tag, 16-bit data.
- **Byte order:** even address returns `word[7:0]`; odd address returns `word[15:8]`.
- **Output register:** holds `out_addr` (15 bits), `out_data` (8 bits) and `out_valid`.
  - `rom_ok = rom_cs & out_valid & (out_addr == rom_addr)`.
  - `rom_data = out_data`.
- **States:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - If `rom_cs` is high and `rom_ok` is low:
    - On a hit, load the output register from the line; stay in IDLE.
    - On a miss, latch `mem_addr <= rom_addr[14:1]`, set `mem_cs`, go to ISSUE.
  - Otherwise hold.
- **ISSUE:** exactly one cycle. `mem_ok` is ignored here, so a stale `ok` from a previous address is never used. Go to WAIT.
- **WAIT:** on `mem_ok` high:
  - Write the line (valid = 1, tag, data).
  - Load the output register using the captured CPU address.
  - Clear `mem_cs`; go to IDLE.
- **Captured address:** the miss-time `rom_addr` is stored. If `rom_cs` drops or the address changes during ISSUE/WAIT, the fill still completes and the line is written. `rom_ok` stays low until the address matches `out_addr`.
- **`flush`:**
  - Clears all valid bits and `out_valid` in the same cycle.
  - In ISSUE or WAIT, the pending fill completes the handshake, but its data is discarded: no line write and no output load.
  - A flush arriving together with `mem_ok` in WAIT also discards that fill.
- **Reset (`snd_rstn` low):**
  - state = IDLE, `mem_cs` = 0, `mem_addr` = 0
  - all valid bits = 0, `out_valid` = 0, `out_addr` = 0, `out_data` = 8'hFF
  - `rom_ok` = 0, `rom_data` = 8'hFF
  - Reset mid-fill abandons the request: `mem_cs` drops immediately.
- Tag/data storage is not reset; only the valid bits are.

## Timing
- **Hit:** `rom_cs` with a new address in cycle N → output register loaded at the end of N → `rom_ok` high in N+1.
- **Miss:**
  - Detected in N; `mem_cs` high and `mem_addr` valid from N+1 (ISSUE); WAIT from N+2.
  - First `mem_ok` sampled in WAIT at cycle M → `rom_ok` high and `mem_cs` low in M+1.
  - Minimum miss latency: `rom_ok` at N+3.
- **`mem_cs`:** held continuously high from ISSUE until the cycle after the accepted `mem_ok`; `mem_addr` is constant throughout.
- **Back-to-back hits:** one per cycle after each address change (CPU-limited).
- **Replacement:** single line per index, so a miss always overwrites it.

## Test plan
- **Reset:**
  - Hold `snd_rstn` low, then release.
  - Require `rom_ok`=0, `rom_data`=8'hFF, `mem_cs`=0.
  - The first access to 0x0000 must miss.
- **Cold miss then hit:**
  - Read 0x0123 with memory word 14'h091 = 16'hBEEF.
  - Require `mem_addr`=0x091, `mem_cs` from N+1, `rom_data`=8'hBE (odd address).
  - A re-read of 0x0122 gives 8'hEF in 1 cycle with no `mem_cs`.
- **Conflict eviction:**
  - Read 0x0002, then 0x0022 (same index 1, different tag).
  - Both must miss. Re-reading 0x0002 must miss again.
- **Stale `ok`:**
  - Hold `mem_ok` high continuously.
  - Require data to be accepted only in WAIT, i.e. `rom_ok` at N+3 with the correct word.
- **Abandon and flush:**
  - Drop `rom_cs` during WAIT → the line is still written; a later read of that address is a hit.
  - Assert `flush` in WAIT → no write; the next read misses.
- **Reset mid-fill:**
  - Pull `snd_rstn` low in WAIT.
  - `mem_cs` must drop asynchronously, and all lines must be invalid after release.
